// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response channel of the data-memory access unit.
// The unit sits on the slave side; the MEM stage drives the master side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_exc;

    modport master (
        output req_valid, req_write, req_size, req_sign, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_exc
    );

    modport slave (
        input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_exc
    );
endinterface

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: accepts one load/store, checks alignment,
// strobes DataMemory and returns a single response that the pipeline must acknowledge.
module mem_access_unit #(
    parameter int unsigned ReadLatency = 1,
    parameter bit          CheckAlign  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_access_unit_if.slave   pipe,
    output logic [31:0]        addr_o,
    output logic [31:0]        din_o,
    output logic               mem_write_o,
    output logic               mem_read_o,
    output logic [1:0]         mem_size_o,
    output logic               mem_sign_o,
    input  logic [31:0]        dout_i,
    input  logic               exception_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Counter reloads to ReadLatency-1 so that zero marks the final read cycle.
    localparam logic [3:0] LoadCnt = 4'(ReadLatency - 1);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;
    logic        misaligned;

    always_comb begin
        misaligned = 1'b0;
        unique case (pipe.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = pipe.req_addr[0];
            2'b10:   misaligned = |pipe.req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        unique case (state_q)
            StIdle: begin
                if (pipe.req_valid) begin
                    write_d = pipe.req_write;
                    size_d  = pipe.req_size;
                    sign_d  = pipe.req_sign;
                    addr_d  = pipe.req_addr;
                    wdata_d = pipe.req_wdata;
                    cnt_d   = LoadCnt;
                    rdata_d = 32'h0;
                    exc_d   = 1'b0;
                    if (CheckAlign && misaligned) begin
                        exc_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (write_q) begin
                    exc_d   = exception_i;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end else if (cnt_q == 4'd0) begin
                    exc_d   = exception_i;
                    rdata_d = exception_i ? 32'h0 : dout_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (pipe.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    // Strobes decode straight from the state so an asynchronous reset drops them at once.
    assign mem_write_o = (state_q == StAccess) && write_q;
    assign mem_read_o  = (state_q == StAccess) && !write_q;
    assign addr_o      = addr_q;
    assign din_o       = wdata_q;
    assign mem_size_o  = size_q;
    assign mem_sign_o  = sign_q;

    assign pipe.req_ready  = (state_q == StIdle);
    assign pipe.resp_valid = (state_q == StResp);
    assign pipe.resp_rdata = rdata_q;
    assign pipe.resp_exc   = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, held-response and reset corner cases,
// then random traffic against a transaction-level memory model.
module tb_mem_access_unit;

    localparam int unsigned RL = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] addr_o, din_o, dout_i;
    logic        mem_write_o, mem_read_o, mem_sign_o, exception_i;
    logic [1:0]  mem_size_o;

    mem_access_unit_if pipe ();

    mem_access_unit #(
        .ReadLatency (RL),
        .CheckAlign  (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pipe        (pipe.slave),
        .addr_o      (addr_o),
        .din_o       (din_o),
        .mem_write_o (mem_write_o),
        .mem_read_o  (mem_read_o),
        .mem_size_o  (mem_size_o),
        .mem_sign_o  (mem_sign_o),
        .dout_i      (dout_i),
        .exception_i (exception_i)
    );

    always #5 clk_i = ~clk_i;

    // DataMemory stand-in: 256 bytes, little-endian, exception above 0xFF.
    bit [7:0] mem_arr [0:255];
    int       wr_cnt = 0;
    int       rd_cnt = 0;

    assign exception_i = (mem_read_o || mem_write_o) && (addr_o >= 32'h100);

    always_comb begin
        logic [7:0] a;
        a = addr_o[7:0];
        dout_i = 32'h0;
        case (mem_size_o)
            2'b00:   dout_i = mem_sign_o ? {{24{mem_arr[a][7]}}, mem_arr[a]}
                                         : {24'h0, mem_arr[a]};
            2'b01:   dout_i = mem_sign_o ? {{16{mem_arr[a+8'd1][7]}}, mem_arr[a+8'd1], mem_arr[a]}
                                         : {16'h0, mem_arr[a+8'd1], mem_arr[a]};
            default: dout_i = {mem_arr[a+8'd3], mem_arr[a+8'd2], mem_arr[a+8'd1], mem_arr[a]};
        endcase
    end

    always @(posedge clk_i) begin
        if (mem_write_o) wr_cnt <= wr_cnt + 1;
        if (mem_read_o) rd_cnt <= rd_cnt + 1;
        if (mem_write_o && !exception_i) begin
            mem_arr[addr_o[7:0]] <= din_o[7:0];
            if (mem_size_o != 2'b00) mem_arr[addr_o[7:0] + 8'd1] <= din_o[15:8];
            if (mem_size_o == 2'b10) begin
                mem_arr[addr_o[7:0] + 8'd2] <= din_o[23:16];
                mem_arr[addr_o[7:0] + 8'd3] <= din_o[31:24];
            end
        end
    end

    // Reference model: byte array updated once per completed transaction.
    bit [7:0] ref_mem [0:255];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit is_trap(input logic [1:0] size, input logic [31:0] addr);
        int unsigned a = addr;
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sign,
                                             input logic [31:0] addr);
        int unsigned a = addr % 256;
        int unsigned v;
        int unsigned nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        v = 0;
        for (int k = 0; k < nbytes; k++) v = v + (int'(ref_mem[(a + k) % 256]) << (8 * k));
        if (sign && nbytes == 1 && v >= 128) v = v + 32'hFFFFFF00;
        if (sign && nbytes == 2 && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int unsigned nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int k = 0; k < nbytes; k++) ref_mem[(addr + k) % 256] = wdata[8*k +: 8];
    endtask

    // One transaction; hold>0 keeps resp_ready low that many cycles while a stray
    // request is offered, which must be ignored.
    task automatic run_txn(input string tag, input bit wr, input logic [1:0] size, input bit sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input bit exp_exc, input int hold);
        bit trap = is_trap(size, addr);
        int exp_lat = trap ? 1 : (wr ? 2 : 1 + RL);
        int lat = 1;
        int w0, r0;
        @(negedge clk_i);
        chk({tag, "_req_ready"}, pipe.req_ready, 1'b1);
        w0 = wr_cnt;
        r0 = rd_cnt;
        pipe.req_valid = 1'b1;
        pipe.req_write = wr;
        pipe.req_size  = size;
        pipe.req_sign  = sign;
        pipe.req_addr  = addr;
        pipe.req_wdata = wdata;
        @(posedge clk_i);
        #1;
        pipe.req_valid = 1'b0;
        while (!pipe.resp_valid && lat < 50) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, pipe.resp_rdata, exp_rdata);
        chk({tag, "_exc"}, pipe.resp_exc, exp_exc);
        chk({tag, "_wr_pulses"}, wr_cnt - w0, (!trap && wr) ? 1 : 0);
        chk({tag, "_rd_cycles"}, rd_cnt - r0, (!trap && !wr) ? RL : 0);
        if (!trap) begin
            chk({tag, "_addr"}, addr_o, addr);
            chk({tag, "_size"}, mem_size_o, size);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            pipe.req_valid = 1'b1;
            pipe.req_write = 1'b1;
            pipe.req_size  = 2'b10;
            pipe.req_addr  = 32'h10;
            chk({tag, "_hold_valid"}, pipe.resp_valid, 1'b1);
            chk({tag, "_hold_rdata"}, pipe.resp_rdata, exp_rdata);
            chk({tag, "_hold_ready"}, pipe.req_ready, 1'b0);
        end
        @(negedge clk_i);
        pipe.req_valid  = 1'b0;
        pipe.resp_ready = 1'b1;
        @(posedge clk_i);
        #1;
        pipe.resp_ready = 1'b0;
        chk({tag, "_idle_ready"}, pipe.req_ready, 1'b1);
        chk({tag, "_idle_valid"}, pipe.resp_valid, 1'b0);
        if (hold > 0) chk({tag, "_stray_ignored"}, wr_cnt - w0, (!trap && wr) ? 1 : 0);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_exc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        pipe.req_valid  = 1'b0;
        pipe.req_write  = 1'b0;
        pipe.req_size   = 2'b00;
        pipe.req_sign   = 1'b0;
        pipe.req_addr   = 32'h0;
        pipe.req_wdata  = 32'h0;
        pipe.resp_ready = 1'b0;

        vecs.push_back('{1, 2'b10, 0, 32'h0,   32'h12345678, 32'h0,        0}); // sw
        vecs.push_back('{1, 2'b01, 0, 32'h4,   32'h12345678, 32'h0,        0}); // sh
        vecs.push_back('{1, 2'b00, 0, 32'h6,   32'hFFFFFFFF, 32'h0,        0}); // sb
        vecs.push_back('{1, 2'b00, 0, 32'h7,   32'hEEEEEEEE, 32'h0,        0}); // sb
        vecs.push_back('{0, 2'b01, 1, 32'h6,   32'h0,        32'hFFFFEEFF, 0}); // lh
        vecs.push_back('{0, 2'b01, 0, 32'h6,   32'h0,        32'h0000EEFF, 0}); // lhu
        vecs.push_back('{0, 2'b10, 0, 32'h0,   32'h0,        32'h12345678, 0}); // lw
        vecs.push_back('{0, 2'b10, 0, 32'h4,   32'h0,        32'hEEFF5678, 0}); // lw
        vecs.push_back('{0, 2'b00, 1, 32'h5,   32'h0,        32'h00000056, 0}); // lb
        vecs.push_back('{0, 2'b00, 1, 32'h6,   32'h0,        32'hFFFFFFFF, 0}); // lb
        vecs.push_back('{0, 2'b00, 0, 32'h7,   32'h0,        32'h000000EE, 0}); // lbu
        vecs.push_back('{0, 2'b10, 0, 32'h3,   32'h0,        32'h0,        1}); // misaligned lw
        vecs.push_back('{0, 2'b01, 0, 32'h1,   32'h0,        32'h0,        1}); // misaligned lh
        vecs.push_back('{1, 2'b11, 0, 32'h0,   32'h0,        32'h0,        1}); // reserved size
        vecs.push_back('{1, 2'b10, 0, 32'h200, 32'hDEADBEEF, 32'h0,        1}); // memory exception
        vecs.push_back('{0, 2'b10, 0, 32'h200, 32'h0,        32'h0,        1}); // memory exception

        #12;
        chk("rst_req_ready", pipe.req_ready, 1'b1);
        chk("rst_resp_valid", pipe.resp_valid, 1'b0);
        chk("rst_resp_rdata", pipe.resp_rdata, 32'h0);
        chk("rst_resp_exc", pipe.resp_exc, 1'b0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_din", din_o, 32'h0);
        chk("rst_strobes", {mem_write_o, mem_read_o, mem_size_o, mem_sign_o}, 5'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].sign,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_exc, 0);
            if (vecs[i].wr && !vecs[i].exp_exc)
                ref_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // Held response with a stray request offered during RESP.
        run_txn("hold", 0, 2'b10, 0, 32'h0, 32'h0, 32'h12345678, 0, 5);

        // Reset in the middle of a multi-cycle load.
        @(negedge clk_i);
        pipe.req_valid = 1'b1;
        pipe.req_write = 1'b0;
        pipe.req_size  = 2'b10;
        pipe.req_addr  = 32'h4;
        @(negedge clk_i);
        pipe.req_valid = 1'b0;
        chk("midrst_read_active", mem_read_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_read", mem_read_o, 1'b0);
        chk("midrst_write", mem_write_o, 1'b0);
        chk("midrst_req_ready", pipe.req_ready, 1'b1);
        chk("midrst_resp_valid", pipe.resp_valid, 1'b0);
        chk("midrst_addr", addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_txn("post_rst", 0, 2'b10, 0, 32'h4, 32'h0, 32'hEEFF5678, 0, 0);

        for (int n = 0; n < 40; n++) begin
            bit          wr   = 1'($urandom % 2);
            logic [1:0]  size = 2'($urandom % 4);
            bit          sign = 1'($urandom % 2);
            logic [31:0] addr = $urandom_range(0, 32'h10F);
            logic [31:0] wd   = $urandom;
            bit          exc  = is_trap(size, addr) || (addr >= 32'h100);
            logic [31:0] exp_r = (wr || exc) ? 32'h0 : ref_load(size, sign, addr);
            run_txn($sformatf("rnd%0d", n), wr, size, sign, addr, wd, exp_r, exc,
                    int'($urandom % 2));
            if (wr && !exc) ref_store(size, addr, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
